ex_flag_commit_stage: RTL and testbench

Downstream neighbour of the execute-stage 16-bit saturating add/sub unit. Consumes that unit's Sum/Error plus the ALU opcode and updates the architectural Z/V/N flag register according to per-opcode rules. Registers the result into the EX/MEM pipeline register. Evaluates the 3-bit branch condition code against bypassed flags for the branch unit.

---
 rtl/ex_flag_commit_stage_pkg.sv | 29 ++
 rtl/ex_flag_commit_stage_br_cond_eval.sv | 28 ++
 rtl/ex_flag_commit_stage.sv | 89 ++++++++
 tb/tb_ex_flag_commit_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_flag_commit_stage_pkg.sv
// rtl/ex_flag_commit_stage_pkg.sv - shared execute-stage opcodes, branch condition codes and flag indices
package ex_flag_commit_stage_pkg;

    // ALU opcodes
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    // Branch condition codes
    localparam logic [2:0] CCC_NE     = 3'b000;
    localparam logic [2:0] CCC_EQ     = 3'b001;
    localparam logic [2:0] CCC_GT     = 3'b010;
    localparam logic [2:0] CCC_LT     = 3'b011;
    localparam logic [2:0] CCC_GE     = 3'b100;
    localparam logic [2:0] CCC_LE     = 3'b101;
    localparam logic [2:0] CCC_OVF    = 3'b110;
    localparam logic [2:0] CCC_ALWAYS = 3'b111;

    // Bit positions inside the packed {Z, V, N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/ex_flag_commit_stage_br_cond_eval.sv
// rtl/ex_flag_commit_stage_br_cond_eval.sv - combinational branch condition evaluator
// Ports: ccc (condition code), z/v/n (flags to test), taken (condition holds).
module br_cond_eval
    import ex_flag_commit_stage_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       z,
    input  logic       v,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CCC_NE:     taken = ~z;
            CCC_EQ:     taken = z;
            CCC_GT:     taken = ~z & ~n;
            CCC_LT:     taken = n;
            CCC_GE:     taken = z | ~n;
            CCC_LE:     taken = n | z;
            CCC_OVF:    taken = v;
            CCC_ALWAYS: taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_commit_stage.sv
// rtl/ex_flag_commit_stage.sv - Z/V/N flag update, EX/MEM register and bypassed branch condition
// Ports: clk/rst (sync active-high); ex_* execute-stage instruction and result;
// stall holds EX/MEM and flags; br_ccc condition code from decode;
// mem_* registered EX/MEM outputs; flag_z/v/n architectural flags;
// br_taken combinational condition outcome on bypassed flags.
module ex_flag_commit_stage
    import ex_flag_commit_stage_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_opcode,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_ovf,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_wr,
    input  logic                  ex_kill,
    input  logic                  stall,
    input  logic [2:0]            br_ccc,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_result,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_wr,
    output logic                  flag_z,
    output logic                  flag_v,
    output logic                  flag_n,
    output logic                  br_taken
);

    logic [2:0] flags;
    logic [2:0] next_flags;
    logic       commit;
    logic       res_zero;

    assign commit   = ex_valid & ~ex_kill & ~stall;
    assign res_zero = (ex_result == '0);

    // next_flags doubles as the bypass value: it equals the current flags
    // whenever nothing commits, so decode always sees the up-to-date view.
    always_comb begin
        next_flags = flags;
        if (commit) begin
            case (ex_opcode)
                OP_ADD, OP_SUB: begin
                    next_flags[FLAG_Z] = res_zero;
                    next_flags[FLAG_V] = ex_ovf;
                    next_flags[FLAG_N] = ex_result[DATA_W-1];
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    next_flags[FLAG_Z] = res_zero;
                end
                default: next_flags = flags;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags      <= '0;
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_rd     <= '0;
            mem_reg_wr <= 1'b0;
        end else if (!stall) begin
            flags      <= next_flags;
            mem_valid  <= commit;
            // Bubbles load zeros so stale data never lingers in EX/MEM.
            mem_result <= commit ? ex_result : '0;
            mem_rd     <= commit ? ex_rd : '0;
            mem_reg_wr <= commit & ex_reg_wr;
        end
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_v = flags[FLAG_V];
    assign flag_n = flags[FLAG_N];

    br_cond_eval u_br_cond_eval (
        .ccc   (br_ccc),
        .z     (next_flags[FLAG_Z]),
        .v     (next_flags[FLAG_V]),
        .n     (next_flags[FLAG_N]),
        .taken (br_taken)
    );

endmodule

// File: tb/tb_ex_flag_commit_stage.sv
// tb/tb_ex_flag_commit_stage.sv - self-checking bench for ex_flag_commit_stage
module tb_ex_flag_commit_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovf;
    logic [3:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_kill;
    logic        stall;
    logic [2:0]  br_ccc;
    logic        mem_valid;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_reg_wr;
    logic        flag_z, flag_v, flag_n;
    logic        br_taken;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clk = ~clk;

    ex_flag_commit_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_result  (ex_result),
        .ex_ovf     (ex_ovf),
        .ex_rd      (ex_rd),
        .ex_reg_wr  (ex_reg_wr),
        .ex_kill    (ex_kill),
        .stall      (stall),
        .br_ccc     (br_ccc),
        .mem_valid  (mem_valid),
        .mem_result (mem_result),
        .mem_rd     (mem_rd),
        .mem_reg_wr (mem_reg_wr),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .br_taken   (br_taken)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit        m_z, m_v, m_n;
    bit        m_valid, m_reg_wr;
    bit [15:0] m_result;
    bit [3:0]  m_rd;

    function automatic bit is_arith(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1);
    endfunction

    function automatic bit is_zonly(input logic [3:0] op);
        return (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    endfunction

    function automatic bit [2:0] model_next_flags();
        bit [2:0] f;
        f = {m_z, m_v, m_n};
        if (ex_valid && !ex_kill && !stall) begin
            if (is_arith(ex_opcode)) f = {ex_result == 16'h0, ex_ovf, ex_result[15]};
            else if (is_zonly(ex_opcode)) f[2] = (ex_result == 16'h0);
        end
        return f;
    endfunction

    function automatic bit model_taken(input logic [2:0] ccc, input bit [2:0] f);
        bit z, v, n;
        bit [7:0] table_v;
        z = f[2]; v = f[1]; n = f[0];
        table_v = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
        return table_v[ccc];
    endfunction

    always @(posedge clk) begin
        bit [2:0] nf;
        nf = model_next_flags();
        if (rst) begin
            {m_z, m_v, m_n} = 3'b000;
            m_valid = 0; m_reg_wr = 0; m_result = 0; m_rd = 0;
        end else if (!stall) begin
            {m_z, m_v, m_n} = nf;
            m_valid  = ex_valid && !ex_kill;
            m_reg_wr = m_valid && ex_reg_wr;
            m_result = m_valid ? ex_result : 16'h0;
            m_rd     = m_valid ? ex_rd : 4'h0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_flag_z", {31'b0, flag_z}, {31'b0, m_z});
            check("cmp_flag_v", {31'b0, flag_v}, {31'b0, m_v});
            check("cmp_flag_n", {31'b0, flag_n}, {31'b0, m_n});
            check("cmp_mem_valid", {31'b0, mem_valid}, {31'b0, m_valid});
            check("cmp_mem_reg_wr", {31'b0, mem_reg_wr}, {31'b0, m_reg_wr});
            if (m_valid) begin
                check("cmp_mem_result", {16'b0, mem_result}, {16'b0, m_result});
                check("cmp_mem_rd", {28'b0, mem_rd}, {28'b0, m_rd});
            end
            check("cmp_br_taken", {31'b0, br_taken},
                  {31'b0, model_taken(br_ccc, model_next_flags())});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ovf, input logic [3:0] rd, input logic wr,
                         input logic kill, input logic stl, input logic [2:0] ccc);
        ex_valid = v; ex_opcode = op; ex_result = res; ex_ovf = ovf;
        ex_rd = rd; ex_reg_wr = wr; ex_kill = kill; stall = stl; br_ccc = ccc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst = 1'b1;
        drive(1, 4'd0, 16'h0000, 0, 4'd1, 1, 0, 0, 3'b001);
        // 1. reset dominates a valid ADD of zero
        tick();
        rst = 1'b0;
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 3'b001);
        chk_en = 1'b1;
        check("rst_flag_z", {31'b0, flag_z}, 32'd0);
        check("rst_flag_v", {31'b0, flag_v}, 32'd0);
        check("rst_flag_n", {31'b0, flag_n}, 32'd0);
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_br_eq", {31'b0, br_taken}, 32'd0);

        // 2. ADD positive saturation with overflow, bypass to OVF branch
        drive(1, 4'd0, 16'h7FFF, 1, 4'd3, 1, 0, 0, 3'b110);
        check("add_bypass_ovf", {31'b0, br_taken}, 32'd1);
        tick();
        check("add_flag_v", {31'b0, flag_v}, 32'd1);
        check("add_flag_n", {31'b0, flag_n}, 32'd0);
        check("add_flag_z", {31'b0, flag_z}, 32'd0);
        check("add_mem_result", {16'b0, mem_result}, 32'h7FFF);
        check("add_mem_valid", {31'b0, mem_valid}, 32'd1);

        // 3. XOR zero sets Z only, then SUB negative saturation
        drive(1, 4'd2, 16'h0000, 0, 4'd4, 1, 0, 0, 3'b001);
        check("xor_bypass_eq", {31'b0, br_taken}, 32'd1);
        tick();
        check("xor_z", {31'b0, flag_z}, 32'd1);
        check("xor_v_held", {31'b0, flag_v}, 32'd1);
        check("xor_n_held", {31'b0, flag_n}, 32'd0);
        drive(1, 4'd1, 16'h8000, 1, 4'd6, 1, 0, 0, 3'b011);
        check("sub_bypass_lt", {31'b0, br_taken}, 32'd1);
        tick();
        check("sub_flags", {29'b0, flag_z, flag_v, flag_n}, 32'b011);

        // 4. PADDSB of zero leaves flags alone
        drive(1, 4'd7, 16'h0000, 0, 4'd5, 1, 0, 0, 3'b001);
        tick();
        check("paddsb_z_held", {31'b0, flag_z}, 32'd0);
        check("paddsb_reg_wr", {31'b0, mem_reg_wr}, 32'd1);
        check("paddsb_rd", {28'b0, mem_rd}, 32'd5);

        // 5. three stalled cycles presenting a flag-setting ADD
        drive(1, 4'd0, 16'h0000, 0, 4'd9, 0, 0, 1, 3'b001);
        check("stall_br_old", {31'b0, br_taken}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_flags", {29'b0, flag_z, flag_v, flag_n}, 32'b011);
            check("stall_mem_rd", {28'b0, mem_rd}, 32'd5);
            check("stall_mem_valid", {31'b0, mem_valid}, 32'd1);
        end

        // 6. kill produces a bubble; stall+kill holds everything
        drive(1, 4'd0, 16'h0000, 0, 4'd9, 1, 1, 0, 3'b001);
        tick();
        check("kill_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("kill_reg_wr", {31'b0, mem_reg_wr}, 32'd0);
        check("kill_z_held", {31'b0, flag_z}, 32'd0);
        drive(1, 4'd0, 16'h0001, 0, 4'd2, 1, 0, 0, 3'b000);
        tick();
        drive(1, 4'd0, 16'h0000, 0, 4'd8, 1, 1, 1, 3'b001);
        tick();
        check("stallkill_valid", {31'b0, mem_valid}, 32'd1);
        check("stallkill_result", {16'b0, mem_result}, 32'h0001);
        check("stallkill_z", {31'b0, flag_z}, 32'd0);
        drive(1, 4'd0, 16'h0000, 0, 4'd8, 1, 1, 0, 3'b001);
        tick();
        check("kill_after_stall", {31'b0, mem_valid}, 32'd0);

        // reset during stall still clears
        drive(1, 4'd1, 16'hFFFF, 1, 4'd7, 1, 0, 0, 3'b000);
        tick();
        rst = 1'b1;
        drive(1, 4'd0, 16'h1234, 0, 4'd1, 1, 0, 1, 3'b000);
        tick();
        rst = 1'b0;
        check("rst_stall_flags", {29'b0, flag_z, flag_v, flag_n}, 32'b000);
        check("rst_stall_valid", {31'b0, mem_valid}, 32'd0);

        // directed sweep across opcodes and every condition code
        vecs[0] = '{4'd0, 16'h0000, 1'b0};
        vecs[1] = '{4'd1, 16'hFFF0, 1'b0};
        vecs[2] = '{4'd3, 16'h0000, 1'b0};
        vecs[3] = '{4'd4, 16'h0000, 1'b0};
        vecs[4] = '{4'd5, 16'h8001, 1'b0};
        vecs[5] = '{4'd6, 16'h0000, 1'b0};
        vecs[6] = '{4'd8, 16'h0000, 1'b1};
        vecs[7] = '{4'd0, 16'h7FFF, 1'b1};
        vecs[8] = '{4'd15, 16'h0000, 1'b0};
        vecs[9] = '{4'd1, 16'h0000, 1'b0};
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 10; i++) begin
                drive(1'b1, vecs[i].op, vecs[i].res, vecs[i].ovf, 4'(i), 1'(i % 2),
                      1'(i == 3 && c == 2), 1'(i == 5 && c == 4), 3'((c + i) % 8));
                tick();
            end
        end
        drive(0, 4'd0, 16'h0000, 0, 4'd0, 0, 0, 0, 3'b111);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
